spi_exe_master: RTL

- SPI master that sits directly upstream of the SPI execution-unit slave and drives its i_sclk/i_mosi/i_cs and consumes its o_miso.
- Accepts one command (oper, argA, argB) per valid/ready handshake and serialises it MSB-first.
- Clocks the slave through a turnaround gap, then shifts in the 28-bit response (result, flags, 16-bit pad).
- Presents result and flags in parallel with a one-cycle done pulse.

---
 rtl/spi_exe_master_if.sv | 37 +++
 rtl/spi_exe_master.sv | 138 +++++++++++++
 2 files changed

// File: rtl/spi_exe_master_if.sv
// Bus bundle between the SPI execution-unit master and its user/slave side.
// Macro SPI_EXE_MASTER_PAD_CHECK_EN adds the o_err pad-check output.
interface spi_exe_master_if #(
    parameter int M = 8
);
    logic         i_valid;
    logic         o_ready;
    logic [M-1:0] i_oper;
    logic [M-1:0] i_argA;
    logic [M-1:0] i_argB;
    logic         o_sclk;
    logic         o_cs_n;
    logic         o_mosi;
    logic         i_miso;
    logic [M-1:0] o_result;
    logic [3:0]   o_flags;
    logic         o_done;
`ifdef SPI_EXE_MASTER_PAD_CHECK_EN
    logic         o_err;
`endif

    modport master (
        input  i_valid, i_oper, i_argA, i_argB, i_miso,
        output o_ready, o_sclk, o_cs_n, o_mosi, o_result, o_flags, o_done
`ifdef SPI_EXE_MASTER_PAD_CHECK_EN
        , output o_err
`endif
    );

    modport slave (
        output i_valid, i_oper, i_argA, i_argB, i_miso,
        input  o_ready, o_sclk, o_cs_n, o_mosi, o_result, o_flags, o_done
`ifdef SPI_EXE_MASTER_PAD_CHECK_EN
        , input o_err
`endif
    );
endinterface

// File: rtl/spi_exe_master.sv
// Mode-0 SPI master: sends {oper,argA,argB}, idles GAP_BITS clocks, reads a RESP_BITS reply.
// Macro SPI_EXE_MASTER_PAD_CHECK_EN adds o_err, set when the reply pad bits are non-zero.
module spi_exe_master #(
    parameter int CLK_DIV   = 4,
    parameter int M         = 8,
    parameter int RESP_BITS = 28,
    parameter int GAP_BITS  = 2
) (
    input  logic           i_clk_p,
    input  logic           i_rst_n,
    spi_exe_master_if.master bus
);
    localparam int TX_BITS = 3 * M;
    localparam int BIT_MAX = (TX_BITS > RESP_BITS) ? TX_BITS : RESP_BITS;
    localparam int BIT_W   = $clog2(BIT_MAX);
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int PAD_W   = RESP_BITS - M - 4;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_TX, S_GAP, S_RX, S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [DIV_W-1:0]     r_div;
    logic [BIT_W-1:0]     r_bit;
    logic                 r_sclk;
    logic                 r_cs_n;
    logic                 r_done;
    logic [TX_BITS-1:0]   r_tx;
    logic [RESP_BITS-1:0] r_rx;
    logic [M-1:0]         r_result;
    logic [3:0]           r_flags;
`ifdef SPI_EXE_MASTER_PAD_CHECK_EN
    logic                 r_err;
`endif

    logic w_accept;
    logic w_tick;
    logic w_shift_phase;
    logic w_rise;
    logic w_fall;
    logic w_bit_last;

    assign w_accept      = (r_state == S_IDLE) && bus.i_valid;
    assign w_tick        = (r_state != S_IDLE) && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_shift_phase = (r_state == S_TX) || (r_state == S_GAP) || (r_state == S_RX);
    assign w_rise        = w_tick && w_shift_phase && !r_sclk;
    assign w_fall        = w_tick && w_shift_phase && r_sclk;

    // A phase ends on the falling tick that closes its last SCLK cycle.
    always_comb begin
        w_bit_last = 1'b0;
        case (r_state)
            S_TX:    w_bit_last = (r_bit == BIT_W'(TX_BITS - 1));
            S_GAP:   w_bit_last = (r_bit == BIT_W'(GAP_BITS - 1));
            S_RX:    w_bit_last = (r_bit == BIT_W'(RESP_BITS - 1));
            default: w_bit_last = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)              w_state_next = S_SETUP;
            S_SETUP: if (w_tick)                w_state_next = S_TX;
            S_TX:    if (w_fall && w_bit_last)  w_state_next = S_GAP;
            S_GAP:   if (w_fall && w_bit_last)  w_state_next = S_RX;
            S_RX:    if (w_fall && w_bit_last)  w_state_next = S_DONE;
            S_DONE:  if (w_tick)                w_state_next = S_IDLE;
            default:                            w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_p) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk_p) begin
        if (!i_rst_n) begin
            r_div    <= '0;
            r_bit    <= '0;
            r_sclk   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_done   <= 1'b0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_result <= '0;
            r_flags  <= '0;
`ifdef SPI_EXE_MASTER_PAD_CHECK_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;

            if ((r_state == S_IDLE) || w_tick) r_div <= '0;
            else                               r_div <= r_div + 1'b1;

            if (w_tick && w_shift_phase) r_sclk <= ~r_sclk;

            if (w_state_next != r_state) r_bit <= '0;
            else if (w_fall)             r_bit <= r_bit + 1'b1;

            r_cs_n <= (w_state_next == S_IDLE) || (w_state_next == S_DONE);

            // MOSI is the TX MSB; zeros shift in, so the line is 0 once all bits are out.
            if (w_accept)                     r_tx <= {bus.i_oper, bus.i_argA, bus.i_argB};
            else if (r_state == S_TX && w_fall) r_tx <= r_tx << 1;

            if (w_accept)                     r_rx <= '0;
            else if (r_state == S_RX && w_rise) r_rx <= {r_rx[RESP_BITS-2:0], bus.i_miso};

            if ((r_state == S_DONE) && (r_div == '0)) begin
                r_result <= r_rx[RESP_BITS-1 -: M];
                r_flags  <= r_rx[RESP_BITS-M-1 -: 4];
                r_done   <= 1'b1;
`ifdef SPI_EXE_MASTER_PAD_CHECK_EN
                r_err    <= |r_rx[PAD_W-1:0];
`endif
            end
        end
    end

    assign bus.o_ready  = (r_state == S_IDLE);
    assign bus.o_sclk   = r_sclk;
    assign bus.o_cs_n   = r_cs_n;
    assign bus.o_mosi   = r_tx[TX_BITS-1];
    assign bus.o_result = r_result;
    assign bus.o_flags  = r_flags;
    assign bus.o_done   = r_done;
`ifdef SPI_EXE_MASTER_PAD_CHECK_EN
    assign bus.o_err    = r_err;
`endif
endmodule
